// File: rtl/sap1_ctrl_pkg.sv
// sap1_ctrl_pkg: shared SAP-1 controller constants (control bit indices, control words, T-states).
package sap1_ctrl_pkg;
  localparam int NUM_T = 6;
  localparam int CW_WIDTH = 12;
  localparam int CNT_WIDTH = 8;
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;
  localparam logic [CW_WIDTH-1:0] CW_BIT = CW_WIDTH'(1);
  localparam logic [CW_WIDTH-1:0] CW_T1_FETCH = (CW_BIT << CW_EP) | (CW_BIT << CW_LM);
  localparam logic [CW_WIDTH-1:0] CW_T2_FETCH = CW_BIT << CW_CP;
  localparam logic [CW_WIDTH-1:0] CW_T3_FETCH = (CW_BIT << CW_CE) | (CW_BIT << CW_LI);
  localparam logic [CW_WIDTH-1:0] CW_LDA_T4 = (CW_BIT << CW_EI) | (CW_BIT << CW_LM);
  localparam logic [CW_WIDTH-1:0] CW_OUT_T4 = (CW_BIT << CW_EA) | (CW_BIT << CW_LO);
  localparam logic [CW_WIDTH-1:0] CW_LDA_T5 = (CW_BIT << CW_CE) | (CW_BIT << CW_LA);
  localparam logic [CW_WIDTH-1:0] CW_ADD_T5 = (CW_BIT << CW_CE) | (CW_BIT << CW_LB);
  localparam logic [CW_WIDTH-1:0] CW_ADD_T6 = (CW_BIT << CW_LA) | (CW_BIT << CW_EU);
  localparam logic [CW_WIDTH-1:0] CW_SUB_T6 = CW_ADD_T6 | (CW_BIT << CW_SU);
  localparam logic [NUM_T-1:0] T1 = 6'b000001;
  localparam logic [NUM_T-1:0] T2 = 6'b000010;
  localparam logic [NUM_T-1:0] T3 = 6'b000100;
  localparam logic [NUM_T-1:0] T4 = 6'b001000;
  localparam logic [NUM_T-1:0] T5 = 6'b010000;
  localparam logic [NUM_T-1:0] T6 = 6'b100000;
endpackage

// File: rtl/ring_counter.sv
// ring_counter: one-hot T-state ring, resets to T1 and freezes while i_hold is high.
module ring_counter #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         i_hold,
  output logic [N-1:0] o_ring
);
  logic [N-1:0] r_ring;
  always_ff @(posedge clk or posedge clr)
    if (clr) r_ring <= N'(1);
    else if (!i_hold) r_ring <= {r_ring[N-2:0], r_ring[N-1]};
  assign o_ring = r_ring;
endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 control matrix driven by the T-state ring, with halt and retired-instruction count.
import sap1_ctrl_pkg::*;

module controller_sequencer #(
  parameter int NUM_T = sap1_ctrl_pkg::NUM_T,
  parameter int CW_WIDTH = sap1_ctrl_pkg::CW_WIDTH,
  parameter int CNT_WIDTH = sap1_ctrl_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 lda,
  input  logic                 add,
  input  logic                 sub,
  input  logic                 out,
  input  logic                 low_halt,
  output logic [NUM_T-1:0]     t_state,
  output logic [CW_WIDTH-1:0]  control_word,
  output logic                 halted,
  output logic                 instr_done,
  output logic [CNT_WIDTH-1:0] instr_count
);
  logic [NUM_T-1:0] w_t;
  logic w_lda, w_add, w_sub, w_out, w_hlt, w_halt_now;
  logic [CW_WIDTH-1:0] w_cw;
  logic r_halted;
  logic [CNT_WIDTH-1:0] r_count;
  // Strobe priority: lda > add > sub > out > halt.
  assign w_lda = lda;
  assign w_add = add & ~lda;
  assign w_sub = sub & ~lda & ~add;
  assign w_out = out & ~lda & ~add & ~sub;
  assign w_hlt = ~low_halt & ~lda & ~add & ~sub & ~out;
  assign w_halt_now = (w_t == T4) & w_hlt & ~r_halted;
  ring_counter #(.N(NUM_T)) u_ring (
    .clk(clk),
    .clr(clr),
    .i_hold(r_halted | w_halt_now),
    .o_ring(w_t)
  );
  always_comb begin
    w_cw = '0;
    if (!r_halted)
      w_cw = (w_t == T1) ? CW_T1_FETCH :
             (w_t == T2) ? CW_T2_FETCH :
             (w_t == T3) ? CW_T3_FETCH :
             (w_t == T4) ? ((w_lda | w_add | w_sub) ? CW_LDA_T4 : w_out ? CW_OUT_T4 : '0) :
             (w_t == T5) ? (w_lda ? CW_LDA_T5 : (w_add | w_sub) ? CW_ADD_T5 : '0) :
             (w_t == T6) ? (w_add ? CW_ADD_T6 : w_sub ? CW_SUB_T6 : '0) : '0;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_halted <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_halt_now) r_halted <= 1'b1;
      if (instr_done) r_count <= r_count + 1'b1;
    end
  assign t_state = w_t;
  assign control_word = w_cw;
  assign halted = r_halted;
  assign instr_done = w_t[NUM_T-1] & ~r_halted;
  assign instr_count = r_count;
endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: table vectors, hand-written halt/reset sequences and a randomized model comparison.
module tb_controller_sequencer;
  logic clk = 0, clr = 1, lda = 0, add = 0, sub = 0, out = 0, low_halt = 1;
  logic [5:0] t_state;
  logic [11:0] control_word;
  logic halted, instr_done;
  logic [7:0] instr_count;
  int n_checks = 0, n_fail = 0;
  int m_ph = 0, m_cnt = 0;
  bit m_h = 0;

  typedef struct {
    bit l, a, s, o, lh;
    logic [5:0] t;
    logic [11:0] cw;
    bit done;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[24];

  controller_sequencer dut (
    .clk(clk), .clr(clr), .lda(lda), .add(add), .sub(sub), .out(out), .low_halt(low_halt),
    .t_state(t_state), .control_word(control_word), .halted(halted),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cls(bit l, bit a, bit s, bit o, bit lh);
    return l ? 0 : a ? 1 : s ? 2 : o ? 3 : !lh ? 4 : 5;
  endfunction

  // Expected word from instruction class (0 LDA,1 ADD,2 SUB,3 OUT,4 HLT,5 NOP) and phase 0..5.
  function automatic logic [11:0] ref_cw(int ins, int ph, bit h);
    logic [11:0] fetch[3];
    logic [11:0] tail[3];
    fetch = '{12'h600, 12'h800, 12'h180};
    case (ins)
      0: tail = '{12'h240, 12'h120, 12'h000};
      1: tail = '{12'h240, 12'h102, 12'h024};
      2: tail = '{12'h240, 12'h102, 12'h02C};
      3: tail = '{12'h011, 12'h000, 12'h000};
      default: tail = '{12'h000, 12'h000, 12'h000};
    endcase
    if (h) return 12'h000;
    return (ph < 3) ? fetch[ph] : tail[ph-3];
  endfunction

  task automatic check_model(input int ins);
    logic [5:0] et;
    et = 6'(1 << m_ph);
    chk("m_t_state", t_state, et);
    chk("m_control_word", control_word, ref_cw(ins, m_ph, m_h));
    chk("m_halted", halted, m_h);
    chk("m_instr_done", instr_done, (m_ph == 5) && !m_h);
    chk("m_instr_count", instr_count, m_cnt);
  endtask

  task automatic step(input bit l, input bit a, input bit s, input bit o, input bit lh);
    int ins;
    lda = l; add = a; sub = s; out = o; low_halt = lh;
    ins = cls(l, a, s, o, lh);
    #1 check_model(ins);
    @(posedge clk);
    if (!m_h) begin
      if (m_ph == 3 && ins == 4) m_h = 1;
      else begin
        if (m_ph == 5) m_cnt = (m_cnt + 1) % 256;
        m_ph = (m_ph + 1) % 6;
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    clr = 1;
    m_ph = 0; m_h = 0; m_cnt = 0;
    #1 check_model(5);
    @(negedge clk);
    clr = 0;
  endtask

  task automatic fill(input int base, input bit l, input bit a, input bit s, input bit o,
                      input logic [11:0] w4, input logic [11:0] w5, input logic [11:0] w6,
                      input logic [7:0] cnt);
    logic [11:0] w[6];
    w = '{12'h600, 12'h800, 12'h180, w4, w5, w6};
    for (int i = 0; i < 6; i++)
      tbl[base+i] = '{l, a, s, o, 1'b1, 6'(1 << i), w[i], i == 5, cnt};
  endtask

  initial begin
    logic [11:0] la_exp[6];
    fill(0, 1, 0, 0, 0, 12'h240, 12'h120, 12'h000, 8'd0);
    fill(6, 0, 1, 0, 0, 12'h240, 12'h102, 12'h024, 8'd1);
    fill(12, 0, 0, 1, 0, 12'h240, 12'h102, 12'h02C, 8'd2);
    fill(18, 0, 0, 0, 1, 12'h011, 12'h000, 12'h000, 8'd3);
    #12;
    chk("rst_t_state", t_state, 6'h01);
    chk("rst_cw", control_word, 12'h600);
    chk("rst_halted", halted, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_count", instr_count, 0);
    @(negedge clk);
    clr = 0;
    for (int k = 0; k < 24; k++) begin
      lda = tbl[k].l; add = tbl[k].a; sub = tbl[k].s; out = tbl[k].o; low_halt = tbl[k].lh;
      #1;
      chk("tbl_t_state", t_state, tbl[k].t);
      chk("tbl_cw", control_word, tbl[k].cw);
      chk("tbl_done", instr_done, tbl[k].done);
      chk("tbl_count", instr_count, tbl[k].cnt);
      @(negedge clk);
    end
    chk("tbl_final_count", instr_count, 4);
    lda = 0; add = 0; sub = 0; out = 0; low_halt = 1;
    repeat (3) @(negedge clk);
    low_halt = 0;
    #1;
    chk("hlt_t4_cw", control_word, 12'h000);
    chk("hlt_t4_t", t_state, 6'h08);
    chk("hlt_t4_halted", halted, 0);
    @(negedge clk);
    chk("hlt_halted", halted, 1);
    chk("hlt_frozen_t", t_state, 6'h08);
    low_halt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hlt_hold_cw", control_word, 12'h000);
      chk("hlt_hold_t", t_state, 6'h08);
      chk("hlt_hold_count", instr_count, 4);
      chk("hlt_hold_done", instr_done, 0);
    end
    clr = 1;
    #1;
    chk("hlt_clr_t", t_state, 6'h01);
    chk("hlt_clr_cw", control_word, 12'h600);
    chk("hlt_clr_halted", halted, 0);
    @(negedge clk);
    clr = 0;
    lda = 1;
    repeat (4) @(negedge clk);
    chk("async_pre_t", t_state, 6'h10);
    #2 clr = 1;
    #1;
    chk("async_t", t_state, 6'h01);
    chk("async_cw", control_word, 12'h600);
    chk("async_count", instr_count, 0);
    @(negedge clk);
    clr = 0;
    m_ph = 0; m_h = 0; m_cnt = 0;
    for (int i = 0; i < 900; i++) begin
      if (m_h && $urandom_range(0, 3) == 0) reset_pulse();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 15) != 0);
    end
    reset_pulse();
    for (int i = 0; i < 256 * 6; i++) step(0, 0, 0, 0, 1);
    chk("nop_wrap_count", instr_count, 0);
    la_exp = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};
    lda = 1; add = 1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("lda_add_cw", control_word, la_exp[i]);
      @(negedge clk);
    end
    chk("lda_add_count", instr_count, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
